// File: rtl/pcm_sdm_player.sv
// Frame FIFO: registered write/pop, read data is the head entry with no write-to-read bypass.
// Latency: a written frame reaches the head one cycle after the write; level follows by one cycle.
// Backpressure: wr_rdy drops combinationally from the registered level when full.
module pcm_sdm_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_vld,
    input  logic [W-1:0]           wr_dat,
    output logic                   wr_rdy,
    input  logic                   rd_pop,
    output logic                   rd_vld,
    output logic [W-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_en, rd_en;

    assign wr_rdy = (level_q != FULL_LVL);
    assign rd_vld = (level_q != '0);
    assign rd_dat = mem_q[rd_ptr_q];
    assign level  = level_q;
    assign wr_en  = wr_vld && wr_rdy;
    assign rd_en  = rd_pop && rd_vld;

    // Pointer advance and occupancy; a write and a pop together leave the level unchanged.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!wr_en && rd_en) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    // Pointers and level reset asynchronously, which discards the contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; only the pointers need reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_dat;
        end
    end
endmodule

// Multi-channel PCM to first-order sigma-delta bitstream player with frame FIFO.
// Latency: dac and frame_tick are registered, changing the cycle after a modulator tick.
// Backpressure: in_ready = FIFO not full; frames are only popped at frame loads.
module pcm_sdm_player #(
    parameter int BITS       = 16,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int RATE_DIV   = 100,
    parameter int OSR        = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        mute,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*BITS-1:0]    in_data,
    output logic [CHANNELS-1:0]         dac,
    output logic                        frame_tick,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    input  logic                        underrun_clr
);
    localparam int DW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(RATE_DIV - 1);
    localparam logic [PW-1:0]   PH_LAST  = PW'(OSR - 1);
    localparam logic [BITS-1:0] MID      = {1'b1, {(BITS-1){1'b0}}};

    logic [DW-1:0]                    div_q, div_d;
    logic [PW-1:0]                    phase_q, phase_d;
    // Low BITS of each accumulator; the carry bit of the accumulator is dac_q itself.
    logic [CHANNELS-1:0][BITS-1:0]    acc_q, acc_d;
    logic [CHANNELS-1:0][BITS-1:0]    cur_q, cur_d;
    logic [CHANNELS-1:0][BITS:0]      sum;
    logic [CHANNELS-1:0]              dac_q, dac_d;
    logic                             frame_tick_q, frame_tick_d;
    logic                             underrun_q, underrun_d;
    logic                             tick, load, fifo_vld;
    logic [CHANNELS*BITS-1:0]         fifo_dat;

    pcm_sdm_fifo #(
        .W     (CHANNELS*BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_vld (in_valid),
        .wr_dat (in_data),
        .wr_rdy (in_ready),
        .rd_pop (load),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_dat),
        .level  (fifo_level)
    );

    assign tick       = enable && (div_q == DIV_LAST);
    assign load       = tick && (phase_q == PH_LAST);
    assign dac        = dac_q;
    assign frame_tick = frame_tick_q;
    assign underrun   = underrun_q;

    // Tick/phase sequencing, per-channel accumulate and frame load; disable parks everything.
    always_comb begin
        div_d        = div_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        cur_d        = cur_q;
        dac_d        = dac_q;
        frame_tick_d = load;
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c] = {1'b0, acc_q[c]} + {1'b0, cur_q[c]};
        end
        if (!enable) begin
            div_d   = '0;
            phase_d = '0;
            acc_d   = '0;
            cur_d   = {CHANNELS{MID}};
            dac_d   = '0;
        end else if (tick) begin
            div_d   = '0;
            phase_d = load ? '0 : phase_q + PW'(1);
            // The load tick still accumulates the old sample; the new one applies next tick.
            for (int c = 0; c < CHANNELS; c++) begin
                acc_d[c] = sum[c][BITS-1:0];
                dac_d[c] = sum[c][BITS];
                if (load) begin
                    cur_d[c] = (fifo_vld && !mute) ? (fifo_dat[c*BITS +: BITS] ^ MID) : MID;
                end
            end
        end else begin
            div_d = div_q + DW'(1);
        end
        // A new underrun wins over a clear in the same cycle.
        if (load && !fifo_vld) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Sequencer, modulator and status state with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q        <= '0;
            phase_q      <= '0;
            acc_q        <= '0;
            cur_q        <= {CHANNELS{MID}};
            dac_q        <= '0;
            frame_tick_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            div_q        <= div_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            cur_q        <= cur_d;
            dac_q        <= dac_d;
            frame_tick_q <= frame_tick_d;
            underrun_q   <= underrun_d;
        end
    end
endmodule
